// File: rtl/div_sign_wrapper.sv
// Signed/unsigned front end for the unsigned divider: magnitudes out, sign-corrected results back.
// Latency: issue+done+2 cycles, dbz/ovf bypass 1 cycle; one request in flight, result held until out_ready.
module div_sign_wrapper #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_q,
    output logic [WIDTH-1:0] out_r,
    output logic             out_dbz,
    output logic             out_ovf,
    output logic             div_start,
    output logic [WIDTH-1:0] div_a,
    output logic [WIDTH-1:0] div_b,
    input  logic             div_busy,
    input  logic             div_done,
    input  logic [WIDTH-1:0] div_q,
    input  logic [WIDTH-1:0] div_r
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_FIX,
        S_RESP
    } state_t;

    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
        return ~x + ONE;
    endfunction

    state_t           state_q, state_d;
    logic             neg_a_q, neg_a_d;
    logic             neg_b_q, neg_b_d;
    logic [WIDTH-1:0] div_a_q, div_a_d;
    logic [WIDTH-1:0] div_b_q, div_b_d;
    logic             div_start_q, div_start_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;
    logic             ovf_q, ovf_d;

    logic             sa_neg, sb_neg;

    always_comb begin
        state_d     = state_q;
        neg_a_d     = neg_a_q;
        neg_b_d     = neg_b_q;
        div_a_d     = div_a_q;
        div_b_d     = div_b_q;
        div_start_d = 1'b0;
        quo_d       = quo_q;
        rem_d       = rem_q;
        dbz_d       = dbz_q;
        ovf_d       = ovf_q;
        sa_neg      = in_signed & in_a[WIDTH-1];
        sb_neg      = in_signed & in_b[WIDTH-1];

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    neg_a_d = sa_neg;
                    neg_b_d = sb_neg;
                    div_a_d = sa_neg ? negate(in_a) : in_a;
                    div_b_d = sb_neg ? negate(in_b) : in_b;
                    dbz_d   = 1'b0;
                    ovf_d   = 1'b0;
                    if (in_b == '0) begin
                        quo_d   = ALL_ONES;
                        rem_d   = in_a;
                        dbz_d   = 1'b1;
                        state_d = S_RESP;
                    end else if (in_signed && in_a == MOST_NEG && in_b == ALL_ONES) begin
                        quo_d   = MOST_NEG;
                        rem_d   = '0;
                        ovf_d   = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        // Start is registered, so busy is sampled one cycle ahead of the pulse.
                        div_start_d = ~div_busy;
                        state_d     = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (div_start_q) begin
                    state_d = S_WAIT;
                end else if (!div_busy) begin
                    div_start_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (div_done) begin
                    quo_d   = div_q;
                    rem_d   = div_r;
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                // Remainder follows the dividend's sign.
                quo_d   = (neg_a_q ^ neg_b_q) ? negate(quo_q) : quo_q;
                rem_d   = neg_a_q ? negate(rem_q) : rem_q;
                state_d = S_RESP;
            end
            S_RESP: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            neg_a_q     <= 1'b0;
            neg_b_q     <= 1'b0;
            div_a_q     <= '0;
            div_b_q     <= '0;
            div_start_q <= 1'b0;
            quo_q       <= '0;
            rem_q       <= '0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            neg_a_q     <= neg_a_d;
            neg_b_q     <= neg_b_d;
            div_a_q     <= div_a_d;
            div_b_q     <= div_b_d;
            div_start_q <= div_start_d;
            quo_q       <= quo_d;
            rem_q       <= rem_d;
            dbz_q       <= dbz_d;
            ovf_q       <= ovf_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_RESP);
    assign out_q     = quo_q;
    assign out_r     = rem_q;
    assign out_dbz   = dbz_q;
    assign out_ovf   = ovf_q;
    assign div_start = div_start_q;
    assign div_a     = div_a_q;
    assign div_b     = div_b_q;

endmodule

// File: tb/tb_div_sign_wrapper.sv
// Directed bench for div_sign_wrapper; the bench plays the divider with hand-computed results.
module tb_div_sign_wrapper;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        in_signed;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_q;
    logic [15:0] out_r;
    logic        out_dbz;
    logic        out_ovf;
    logic        div_start;
    logic [15:0] div_a;
    logic [15:0] div_b;
    logic        div_busy;
    logic        div_done;
    logic [15:0] div_q;
    logic [15:0] div_r;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    div_sign_wrapper #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_signed (in_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_q     (out_q),
        .out_r     (out_r),
        .out_dbz   (out_dbz),
        .out_ovf   (out_ovf),
        .div_start (div_start),
        .div_a     (div_a),
        .div_b     (div_b),
        .div_busy  (div_busy),
        .div_done  (div_done),
        .div_q     (div_q),
        .div_r     (div_r)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full transaction; cycle 0 is the cycle whose closing edge accepts the request.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic sgn, input int busy, input int hold,
                          input logic [15:0] exp_da, input logic [15:0] exp_db,
                          input logic [15:0] dq, input logic [15:0] dr,
                          input logic [15:0] exp_q, input logic [15:0] exp_r,
                          input logic exp_dbz, input logic exp_ovf);
        int cyc;
        check_val({tag, ":in_ready_idle"}, 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_signed = sgn;
        div_busy  = (busy > 0);
        step();
        in_valid  = 1'b0;
        in_a      = 16'h0;
        in_b      = 16'h0;
        in_signed = 1'b0;
        cyc = 1;
        check_val({tag, ":in_ready_busy"}, 32'(in_ready), 32'd0);
        if (exp_dbz || exp_ovf) begin
            check_val({tag, ":no_start"}, 32'(div_start), 32'd0);
            check_val({tag, ":bypass_valid_c1"}, 32'(out_valid), 32'd1);
        end else begin
            while (!div_start && cyc < 40) begin
                if (cyc >= busy) div_busy = 1'b0;
                step();
                cyc++;
            end
            div_busy = 1'b0;
            check_val({tag, ":start_cycle"}, 32'(cyc), 32'(busy + 1));
            check_val({tag, ":div_a"}, 32'(div_a), 32'(exp_da));
            check_val({tag, ":div_b"}, 32'(div_b), 32'(exp_db));
            step();
            check_val({tag, ":start_pulse"}, 32'(div_start), 32'd0);
            check_val({tag, ":div_a_hold"}, 32'(div_a), 32'(exp_da));
            div_done = 1'b1;
            div_q    = dq;
            div_r    = dr;
            step();
            div_done = 1'b0;
            div_q    = 16'h0;
            div_r    = 16'h0;
            check_val({tag, ":fix_not_valid"}, 32'(out_valid), 32'd0);
            step();
            check_val({tag, ":valid_d2"}, 32'(out_valid), 32'd1);
        end
        check_val({tag, ":q"}, 32'(out_q), 32'(exp_q));
        check_val({tag, ":r"}, 32'(out_r), 32'(exp_r));
        check_val({tag, ":dbz"}, 32'(out_dbz), 32'(exp_dbz));
        check_val({tag, ":ovf"}, 32'(out_ovf), 32'(exp_ovf));
        for (int i = 0; i < hold; i++) begin
            step();
            check_val({tag, ":hold_valid"}, 32'(out_valid), 32'd1);
            check_val({tag, ":hold_q"}, 32'(out_q), 32'(exp_q));
            check_val({tag, ":hold_r"}, 32'(out_r), 32'(exp_r));
            check_val({tag, ":hold_in_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_val({tag, ":valid_drop"}, 32'(out_valid), 32'd0);
        check_val({tag, ":back_idle"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = 16'h0;
        in_b      = 16'h0;
        in_signed = 1'b0;
        out_ready = 1'b0;
        div_busy  = 1'b0;
        div_done  = 1'b0;
        div_q     = 16'h0;
        div_r     = 16'h0;
        repeat (2) step();
        rst = 1'b0;
        step();

        check_val("rst:in_ready", 32'(in_ready), 32'd1);
        check_val("rst:out_valid", 32'(out_valid), 32'd0);
        check_val("rst:div_start", 32'(div_start), 32'd0);
        check_val("rst:out_q", 32'(out_q), 32'd0);
        check_val("rst:out_r", 32'(out_r), 32'd0);
        check_val("rst:div_a", 32'(div_a), 32'd0);
        check_val("rst:div_b", 32'(div_b), 32'd0);
        check_val("rst:flags", {30'd0, out_dbz, out_ovf}, 32'd0);

        //      tag         a        b        s  bsy hold da       db       dq       dr       q        r        dbz  ovf
        run_op("u7_2",    16'h0007, 16'h0002, 1'b0, 0, 0, 16'h0007, 16'h0002, 16'h0003, 16'h0001, 16'h0003, 16'h0001, 1'b0, 1'b0);
        run_op("sn7_2",   16'hFFF9, 16'h0002, 1'b1, 0, 0, 16'h0007, 16'h0002, 16'h0003, 16'h0001, 16'hFFFD, 16'hFFFF, 1'b0, 1'b0);
        run_op("s7_n2",   16'h0007, 16'hFFFE, 1'b1, 0, 0, 16'h0007, 16'h0002, 16'h0003, 16'h0001, 16'hFFFD, 16'h0001, 1'b0, 1'b0);
        run_op("sn7_n2",  16'hFFF9, 16'hFFFE, 1'b1, 0, 0, 16'h0007, 16'h0002, 16'h0003, 16'h0001, 16'h0003, 16'hFFFF, 1'b0, 1'b0);
        run_op("u100_0",  16'h0064, 16'h0000, 1'b0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 16'h0064, 1'b1, 1'b0);
        run_op("sn5_0",   16'hFFFB, 16'h0000, 1'b1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 16'hFFFB, 1'b1, 1'b0);
        run_op("s_ovf",   16'h8000, 16'hFFFF, 1'b1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h8000, 16'h0000, 1'b0, 1'b1);
        run_op("u8000",   16'h8000, 16'hFFFF, 1'b0, 0, 0, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 16'h0000, 16'h8000, 1'b0, 1'b0);
        run_op("busy_hold", 16'd100, 16'd7,   1'b0, 3, 5, 16'd100,  16'd7,    16'd14,   16'd2,    16'd14,   16'd2,    1'b0, 1'b0);

        // Stray completion while idle must not produce a result.
        div_done = 1'b1;
        div_q    = 16'h1234;
        div_r    = 16'h5678;
        step();
        div_done = 1'b0;
        div_q    = 16'h0;
        div_r    = 16'h0;
        step();
        check_val("stray:out_valid", 32'(out_valid), 32'd0);
        check_val("stray:in_ready", 32'(in_ready), 32'd1);
        check_val("stray:out_q", 32'(out_q), 32'd14);

        // Reset while waiting on the divider, then a late completion.
        in_valid = 1'b1;
        in_a     = 16'd20;
        in_b     = 16'd4;
        step();
        in_valid = 1'b0;
        in_a     = 16'h0;
        in_b     = 16'h0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_val("rstw:in_ready", 32'(in_ready), 32'd1);
        check_val("rstw:div_start", 32'(div_start), 32'd0);
        div_done = 1'b1;
        div_q    = 16'd5;
        div_r    = 16'd0;
        step();
        div_done = 1'b0;
        div_q    = 16'h0;
        for (int i = 0; i < 3; i++) begin
            check_val("rstw:no_valid", 32'(out_valid), 32'd0);
            step();
        end
        run_op("after_rst", 16'd9, 16'd3, 1'b0, 2, 0, 16'd9, 16'd3, 16'd3, 16'd0, 16'd3, 16'd0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
